// File: rtl/apb_master_pkg.sv
// Shared types and default widths for the APB master slice.
package apb_master_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH     = 32;
  localparam int unsigned DEFAULT_ADDR_WIDTH     = 32;
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_timeout_counter.sv
// Counts ACCESS wait cycles; expire is asserted on the wait cycle that reaches LIMIT.
module apb_timeout_counter #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expire
);

  localparam int unsigned CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;

  assign expire = inc && (cnt == CW'(LIMIT - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/apb_master.sv
// Command-to-APB bridge: one transfer at a time, registered outputs.
// Optional PREADY timeout abort enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master
  import apb_master_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_slverr,
  output logic                  rsp_timeout,
  output logic                  PSELx,
  output logic                  PENABLE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic                  PREADY,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PSLVERR
);

  apb_state_e state, state_nxt;
  logic       accept;
  logic       done;
  logic       abort;

  assign accept = cmd_valid && cmd_ready;
  assign done   = (state == ACCESS) && PREADY;

`ifdef APB_MASTER_TIMEOUT_EN
  logic expire;

  apb_timeout_counter #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (PCLK),
    .rst   (PRESET),
    .clr   (accept),
    .inc   ((state == ACCESS) && !PREADY),
    .expire(expire)
  );

  assign abort = expire;
`else
  assign abort       = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (PREADY || abort) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus controls are registered from the next state so they line up with it.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state      <= IDLE;
      cmd_ready  <= 1'b1;
      PSELx      <= 1'b0;
      PENABLE    <= 1'b0;
      PADDR      <= '0;
      PWRITE     <= 1'b0;
      PWDATA     <= '0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_slverr <= 1'b0;
    end else begin
      state     <= state_nxt;
      cmd_ready <= (state_nxt == IDLE);
      PSELx     <= (state_nxt != IDLE);
      PENABLE   <= (state_nxt == ACCESS);
      rsp_valid <= done || abort;
      if (accept) begin
        PADDR  <= cmd_addr;
        PWRITE <= cmd_write;
        if (cmd_write) PWDATA <= cmd_wdata;
      end
      if (done) begin
        rsp_rdata  <= PWRITE ? '0 : PRDATA;
        rsp_slverr <= PSLVERR;
      end else if (abort) begin
        rsp_rdata  <= '0;
        rsp_slverr <= 1'b1;
      end
    end
  end

`ifdef APB_MASTER_TIMEOUT_EN
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      rsp_timeout <= 1'b0;
    end else if (done || abort) begin
      rsp_timeout <= abort;
    end
  end
`endif

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: vector table plus multi-cycle corner sequences.
module tb_apb_master;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_slverr, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic        PSELx, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA;
  logic        PREADY, PSLVERR;
  logic [31:0] PRDATA;

  int unsigned total  = 0;
  int unsigned passed = 0;

  always #5 PCLK = ~PCLK;

  apb_master #(
    .DATA_WIDTH    (32),
    .ADDR_WIDTH    (32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .PCLK       (PCLK),
    .PRESET     (PRESET),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_slverr (rsp_slverr),
    .rsp_timeout(rsp_timeout),
    .PSELx      (PSELx),
    .PENABLE    (PENABLE),
    .PADDR      (PADDR),
    .PWRITE     (PWRITE),
    .PWDATA     (PWDATA),
    .PREADY     (PREADY),
    .PRDATA     (PRDATA),
    .PSLVERR    (PSLVERR)
  );

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    int unsigned waits;
    logic [31:0] prdata;
    logic        pslverr;
    logic [31:0] exp_rdata;
    logic        exp_slverr;
    int unsigned exp_lat;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_psel"},   32'(PSELx),       32'd0);
    chk({tag, "_pen"},    32'(PENABLE),     32'd0);
    chk({tag, "_paddr"},  PADDR,            32'd0);
    chk({tag, "_pwrite"}, 32'(PWRITE),      32'd0);
    chk({tag, "_pwdata"}, PWDATA,           32'd0);
    chk({tag, "_rvalid"}, 32'(rsp_valid),   32'd0);
    chk({tag, "_rdata"},  rsp_rdata,        32'd0);
    chk({tag, "_slverr"}, 32'(rsp_slverr),  32'd0);
    chk({tag, "_tmo"},    32'(rsp_timeout), 32'd0);
  endtask

  task automatic do_xfer(input vec_t v);
    int unsigned sel_cyc = 0, en_cyc = 0, waits_seen = 0, lat = 0;
    bit          bus_ok  = 1'b1;
    bit          got     = 1'b0;
    chk("ready_before", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_write = v.write;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    step();
    cmd_valid = 1'b0;
    cmd_addr  = ~v.addr;
    cmd_wdata = ~v.wdata;
    for (int c = 0; c < 40 && !got; c++) begin
      lat++;
      if (rsp_valid) begin
        got = 1'b1;
      end else begin
        if (PSELx) begin
          sel_cyc++;
          if (PADDR !== v.addr || PWRITE !== v.write) bus_ok = 1'b0;
          if (v.write && PWDATA !== v.wdata) bus_ok = 1'b0;
        end
        if (PENABLE) en_cyc++;
        if (PSELx && PENABLE && waits_seen == v.waits) begin
          PREADY  = 1'b1;
          PRDATA  = v.prdata;
          PSLVERR = v.pslverr;
        end else begin
          if (PSELx && PENABLE) waits_seen++;
          PREADY  = 1'b0;
          PRDATA  = ~v.prdata;
          PSLVERR = ~v.pslverr;
        end
        step();
      end
    end
    PREADY = 1'b0;
    if (!got) begin
      chk("rsp_wait_bound", 32'd0, 32'd1);
    end else begin
      chk("latency",    lat,              v.exp_lat);
      chk("psel_cycles", sel_cyc,         v.exp_lat - 1);
      chk("pen_cycles", en_cyc,           v.exp_lat - 2);
      chk("bus_stable", 32'(bus_ok),      32'd1);
      chk("rsp_rdata",  rsp_rdata,        v.exp_rdata);
      chk("rsp_slverr", 32'(rsp_slverr),  32'(v.exp_slverr));
      chk("rsp_tmo",    32'(rsp_timeout), 32'd0);
      chk("done_psel",  32'(PSELx),       32'd0);
      chk("done_ready", 32'(cmd_ready),   32'd1);
      step();
      chk("rvalid_pulse", 32'(rsp_valid), 32'd0);
      chk("rdata_hold",   rsp_rdata,      v.exp_rdata);
      chk("slverr_hold",  32'(rsp_slverr), 32'(v.exp_slverr));
    end
  endtask

  initial begin
    logic [6:0] sel_bits, rv_bits, rdy_bits;

    vecs[0] = '{1'b1, 32'h10,       32'hDEADBEEF, 0, 32'hAAAA5555, 1'b0, 32'h0,        1'b0, 3};
    vecs[1] = '{1'b0, 32'h20,       32'h0,        3, 32'h12345678, 1'b0, 32'h12345678, 1'b0, 6};
    vecs[2] = '{1'b0, 32'h30,       32'h0,        0, 32'hCAFEF00D, 1'b1, 32'hCAFEF00D, 1'b1, 3};
    vecs[3] = '{1'b1, 32'h44,       32'h01234567, 1, 32'h87654321, 1'b1, 32'h0,        1'b1, 4};
    vecs[4] = '{1'b0, 32'hFFFFFFFC, 32'h0,        2, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 5};

    PRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0;
    cmd_addr = '0; cmd_wdata = '0;
    PREADY = 1'b0; PRDATA = '0; PSLVERR = 1'b0;
    repeat (3) step();
    chk_reset_values("reset");
    PRESET = 1'b0;
    chk("ready_after_reset", 32'(cmd_ready), 32'd1);
    step();

    for (int i = 0; i < 5; i++) do_xfer(vecs[i]);

    // Reset during the second ACCESS wait cycle aborts silently.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h200;
    step();
    cmd_valid = 1'b0;
    step();
    step();
    chk("mid_wait2_pen", 32'(PENABLE), 32'd1);
    PRESET = 1'b1;
    step();
    chk_reset_values("midreset");
    PRESET = 1'b0;
    chk("midreset_ready", 32'(cmd_ready), 32'd1);
    step();
    chk("midreset_norsp", 32'(rsp_valid), 32'd0);
    chk("midreset_idle",  32'(PSELx),     32'd0);

    // Back-to-back writes with cmd_valid held high.
    PREADY = 1'b1; PRDATA = '0; PSLVERR = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h100; cmd_wdata = 32'h1;
    step();
    sel_bits = '0; rv_bits = '0; rdy_bits = '0;
    for (int i = 0; i < 7; i++) begin
      sel_bits[i] = PSELx;
      rv_bits[i]  = rsp_valid;
      rdy_bits[i] = cmd_ready;
      if (i == 0) begin
        chk("b2b_addr_a", PADDR, 32'h100);
        cmd_addr = 32'h104; cmd_wdata = 32'h2;
      end
      if (i == 1) chk("b2b_ignore_busy", PADDR, 32'h100);
      if (i == 3) begin
        chk("b2b_addr_b",  PADDR,  32'h104);
        chk("b2b_wdata_b", PWDATA, 32'h2);
      end
      if (i == 5) cmd_valid = 1'b0;
      step();
    end
    PREADY = 1'b0;
    chk("b2b_psel",  32'(sel_bits), 32'(7'b0011011));
    chk("b2b_rsp",   32'(rv_bits),  32'(7'b0100100));
    chk("b2b_ready", 32'(rdy_bits), 32'(7'b1100100));

`ifdef APB_MASTER_TIMEOUT_EN
    begin
      int unsigned en_cyc = 0;
      bit          got    = 1'b0;
      PRDATA = 32'hBAD0BAD0; PSLVERR = 1'b0;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h300;
      step();
      cmd_valid = 1'b0;
      for (int c = 0; c < 40 && !got; c++) begin
        if (rsp_valid) got = 1'b1;
        else begin
          if (PENABLE) en_cyc++;
          step();
        end
      end
      chk("tmo_seen",    32'(got),         32'd1);
      chk("tmo_access",  en_cyc,           32'd4);
      chk("tmo_slverr",  32'(rsp_slverr),  32'd1);
      chk("tmo_flag",    32'(rsp_timeout), 32'd1);
      chk("tmo_rdata",   rsp_rdata,        32'd0);
      chk("tmo_psel",    32'(PSELx),       32'd0);
      step();
      chk("tmo_pulse",   32'(rsp_valid),   32'd0);
    end
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameter DATA_WIDTH, default 32, sets the width of PWDATA, PRDATA, cmd_wdata and rsp_rdata.
REQ-002 Parameter ADDR_WIDTH, default 32, sets the width of PADDR and cmd_addr.
REQ-003 Parameter TIMEOUT_CYCLES, default 16, is the PREADY wait limit; it is used only when APB_MASTER_TIMEOUT_EN is defined.
REQ-004 Port PCLK, input, 1 bit, is the single clock; all logic is rising-edge.
REQ-005 Port PRESET, input, 1 bit, is the reset; it is synchronous and active-high.
REQ-006 Port cmd_valid, input, 1 bit, means a command is offered.
REQ-007 Port cmd_ready, output, 1 bit, means the block can accept a command.
REQ-008 Port cmd_write, input, 1 bit: 1 = write, 0 = read.
REQ-009 Port cmd_addr, input, ADDR_WIDTH bits, is the transfer address.
REQ-010 Port cmd_wdata, input, DATA_WIDTH bits, is the write data.
REQ-011 Port rsp_valid, output, 1 bit, is a one-cycle completion pulse.
REQ-012 Port rsp_rdata, output, DATA_WIDTH bits, is the read data.
REQ-013 Port rsp_slverr, output, 1 bit, is the completion error flag.
REQ-014 Port rsp_timeout, output, 1 bit, means the completion was caused by a timeout abort.
REQ-015 APB master-side ports: PSELx (output, 1), PENABLE (output, 1), PADDR (output, ADDR_WIDTH), PWRITE (output, 1), PWDATA (output, DATA_WIDTH).
REQ-016 APB slave-side ports: PREADY (input, 1), PRDATA (input, DATA_WIDTH), PSLVERR (input, 1).

Function
REQ-017 The FSM SHALL have three states: IDLE, SETUP and ACCESS; all outputs SHALL be registered.
REQ-018 cmd_ready SHALL be 1 only in IDLE; a command SHALL be accepted on a PCLK edge where cmd_valid and cmd_ready are both 1.
REQ-019 On accept, PADDR, PWRITE and PWDATA (writes only) SHALL load from cmd_*, and the state SHALL go IDLE->SETUP.
REQ-020 In SETUP, PSELx=1 and PENABLE=0 for exactly one cycle; the next state SHALL be ACCESS.
REQ-021 In ACCESS, PSELx=1 and PENABLE=1; the block SHALL stay in ACCESS while PREADY=0.
REQ-022 PADDR, PWRITE and PWDATA SHALL stay stable from SETUP to the end of ACCESS, and SHALL hold their last value in IDLE.
REQ-023 When PREADY=1 is sampled in ACCESS, the next cycle SHALL have state=IDLE, PSELx=0, PENABLE=0 and rsp_valid=1 for one cycle.
REQ-024 On that completion, rsp_slverr SHALL equal the sampled PSLVERR and rsp_timeout SHALL be 0.
REQ-025 On that completion, rsp_rdata SHALL equal the sampled PRDATA for reads, and 0 for writes.
REQ-026 Latency: accept at edge k, PREADY already 1 -> rsp_valid high in the cycle after edge k+2.
REQ-027 Latency: each wait cycle (PREADY=0 in ACCESS) adds one cycle.
REQ-028 cmd_ready SHALL rise in the same cycle as rsp_valid, so back-to-back transfers have one IDLE cycle between them.
REQ-029 rsp_rdata and rsp_slverr SHALL hold their values until the next completion; there is no response back-pressure.
REQ-030 cmd_valid while not in IDLE SHALL be ignored and not queued.

Reset
REQ-031 PRESET=1 at any edge SHALL force state=IDLE, PSELx=0, PENABLE=0, PADDR=0, PWRITE=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_slverr=0, rsp_timeout=0, and clear the timeout counter.
REQ-032 After a reset, cmd_ready SHALL be 1 in the first cycle after PRESET falls.
REQ-033 A reset during SETUP or ACCESS SHALL abort the transfer with no rsp_valid pulse.

Configuration
REQ-034 When APB_MASTER_TIMEOUT_EN is defined, a counter SHALL count ACCESS cycles with PREADY=0.
REQ-035 With APB_MASTER_TIMEOUT_EN defined, if the count reaches TIMEOUT_CYCLES, the block SHALL go to IDLE with PSELx=0, PENABLE=0, rsp_valid=1, rsp_slverr=1, rsp_timeout=1, rsp_rdata=0.
REQ-036 With APB_MASTER_TIMEOUT_EN defined, the counter SHALL clear on entry to SETUP.
REQ-037 With APB_MASTER_TIMEOUT_EN defined, PREADY=1 on the same cycle the count reaches TIMEOUT_CYCLES SHALL count as a normal completion.
REQ-038 When APB_MASTER_TIMEOUT_EN is not defined, the block SHALL wait forever for PREADY, rsp_timeout SHALL be tied 0, and no counter SHALL be synthesized.

Structure
REQ-039 Package apb_master_pkg SHALL hold the state enum typedef (IDLE, SETUP, ACCESS) and the default width constants.
REQ-040 The timeout counter SHALL be one sub-module, apb_timeout_counter, instantiated only under APB_MASTER_TIMEOUT_EN.

Verification
REQ-041 Write, zero wait: cmd write, addr 0x10, wdata 0xDEADBEEF, PREADY=1 -> PSELx 2 cycles, PENABLE 1 cycle, rsp_valid 3 cycles after accept, rsp_slverr=0, rsp_rdata=0.
REQ-042 Read, 3 wait states: addr 0x20, PRDATA=0x12345678 when PREADY rises -> ACCESS lasts 4 cycles, PADDR stable throughout, rsp_rdata=0x12345678.
REQ-043 Error response: PSLVERR=1 with PREADY=1 on a read of addr 0x30 -> rsp_slverr=1, then cmd_ready=1.
REQ-044 Back-to-back: cmd_valid held high for two writes -> second accept exactly 1 cycle after rsp_valid of the first, with PSELx low for 1 cycle between them.
REQ-045 Reset mid-ACCESS: PRESET=1 during the 2nd wait cycle -> next cycle all outputs at reset values, no rsp_valid pulse.
REQ-046 Timeout (macro on, TIMEOUT_CYCLES=4): PREADY held 0 -> abort after 4 ACCESS cycles with rsp_valid=1, rsp_slverr=1, rsp_timeout=1.
